bullet_fire_ctrl: RTL

Initiator side of the bullet launch handshake. Turns the player fire button into launch requests for a pool of bullet slots.
- Picks a free slot from the slots' in-use flags.
- Drives that slot's start request and holds it until the slot acknowledges by raising its in-use flag.
- Enforces a frame-count cooldown between shots.
Sits between the input/debounce logic and the bullet instances; runs on the 60 Hz frame clock.

---
 rtl/bullet_fire_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/bullet_fire_ctrl.sv
// Fire-button to bullet-slot launch initiator: one-hot request one frame after the press, held until that slot raises in_use.
// Optional AUTO_FIRE_EN: a held button re-fires from IDLE without needing a new edge.
module bullet_fire_ctrl #(
   parameter int NUM_BULLETS = 4,
   parameter int COOLDOWN    = 8,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                   clk_60hz,
   input  logic                   reset,
   input  logic                   fire_btn,
   input  logic                   dir_in,
   input  logic [NUM_BULLETS-1:0] in_use,
   output logic [NUM_BULLETS-1:0] start_bullet,
   output logic                   direction,
   output logic                   ready,
   output logic [7:0]             shots,
   output logic                   ack_err
);

   localparam logic [7:0] COOL_INIT = 8'(COOLDOWN);
   localparam logic [3:0] TMO_LIMIT = 4'(ACK_TIMEOUT);

   typedef enum logic [1:0] {IDLE, ARM, COOL} state_t;

   state_t     state;
   logic [2:0] sel;
   logic [2:0] free_idx;
   logic [7:0] cool_cnt;
   logic [3:0] tmo_cnt;
   logic       btn_low_q;
   logic [7:0] in_use_pad;
   logic [7:0] sel_onehot;
   logic       none_free;
   logic       press;

   // Unserved slot positions read as busy so they are never picked.
   always_comb begin
      in_use_pad = '1;
      in_use_pad[NUM_BULLETS-1:0] = in_use;
   end

   always_comb begin
      free_idx = '0;
      for (int i = 7; i >= 0; i--) begin
         if (!in_use_pad[i]) free_idx = 3'(i);
      end
   end

   assign none_free  = &in_use_pad;
   assign sel_onehot = 8'd1 << free_idx;
   assign ready      = (state == IDLE) && !none_free;

   // btn_low_q records "button seen released"; clearing it in reset means
   // a button held through reset must be released before it can fire.
`ifdef AUTO_FIRE_EN
   assign press = fire_btn;
`else
   assign press = fire_btn & btn_low_q;
`endif

   always_ff @(posedge clk_60hz) begin
      if (reset) begin
         state        <= IDLE;
         sel          <= '0;
         cool_cnt     <= '0;
         tmo_cnt      <= '0;
         btn_low_q    <= 1'b0;
         start_bullet <= '0;
         direction    <= 1'b0;
         shots        <= '0;
         ack_err      <= 1'b0;
      end else begin
         btn_low_q <= ~fire_btn;
         case (state)
            IDLE: begin
               if (press && !none_free) begin
                  sel          <= free_idx;
                  direction    <= dir_in;
                  start_bullet <= sel_onehot[NUM_BULLETS-1:0];
                  tmo_cnt      <= '0;
                  state        <= ARM;
               end
            end
            ARM: begin
               if (in_use_pad[sel]) begin
                  start_bullet <= '0;
                  if (shots != 8'hFF) shots <= shots + 8'd1;
                  cool_cnt     <= COOL_INIT;
                  state        <= COOL;
               end else if (tmo_cnt + 4'd1 == TMO_LIMIT) begin
                  start_bullet <= '0;
                  ack_err      <= 1'b1;
                  cool_cnt     <= COOL_INIT;
                  state        <= COOL;
               end else begin
                  tmo_cnt <= tmo_cnt + 4'd1;
               end
            end
            COOL: begin
               if (cool_cnt <= 8'd1) begin
                  cool_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  cool_cnt <= cool_cnt - 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
